// File: rtl/ahb_rr_arbiter.sv
// ahb_rr_arbiter
// Burst- and lock-aware AHB arbiter for MASTER_NUMBER masters (1..16).
// Fixed-length bursts (4/8/16 beats) are never split, and a locked owner
// keeps the bus until it drops HLOCK on an accepted transfer.
// Build option: define AHB_ARB_RR_EN for round-robin selection. Without it,
// selection is fixed priority with master 0 highest.
module ahb_rr_arbiter #(
  parameter int MASTER_NUMBER  = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                       hclk,
  input  logic                       hreset,
  input  logic [MASTER_NUMBER-1:0]   busreq,
  input  logic [MASTER_NUMBER-1:0]   hlock,
  input  logic [2*MASTER_NUMBER-1:0] htrans,
  input  logic [3*MASTER_NUMBER-1:0] hburst,
  input  logic                       hready,
  input  logic [1:0]                 hresp,
  output logic [MASTER_NUMBER-1:0]   hgrant,
  output logic [3:0]                 hmaster,
  output logic [3:0]                 hmaster_d,
  output logic                       hmastlock
);

  typedef enum logic [1:0] {
    ST_ARB,
    ST_BURST,
    ST_LOCKED
  } state_e;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] HB_INCR   = 3'd1;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [3:0]               DEF_IDX   = 4'(DEFAULT_MASTER);
  localparam logic [MASTER_NUMBER-1:0] DEF_GRANT = MASTER_NUMBER'(1) << DEFAULT_MASTER;

  state_e                   state_q, state_d;
  logic [3:0]               beat_q, beat_d, beat_next;
  logic [MASTER_NUMBER-1:0] grant_q, grant_d;
  logic [3:0]               owner_q, owner_d;
  logic [3:0]               hmaster_q, hmaster_data_q;
  logic                     hmastlock_q;

  logic [1:0] cur_trans;
  logic [2:0] cur_burst;
  logic       cur_lock;
  logic       cur_req;
  logic       burst_fixed;
  logic [3:0] burst_len_m1;
  logic       lock_enter;
  logic       err_exit;
  logic       regrant;
  logic [3:0] pick_idx;

  // Select the current owner's transfer-control fields.
  // NOTE: every always_comb output gets a default before any branch so that
  // no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    cur_trans = TR_IDLE;
    cur_burst = '0;
    cur_lock  = 1'b0;
    cur_req   = 1'b0;
    for (int i = 0; i < MASTER_NUMBER; i++) begin
      if (owner_q == 4'(i)) begin
        cur_trans = htrans[2*i +: 2];
        cur_burst = hburst[3*i +: 3];
        cur_lock  = hlock[i];
        cur_req   = busreq[i];
      end
    end
  end

  // Decode the owner's HBURST into "fixed length" and beats-remaining-after-first.
  always_comb begin
    burst_fixed  = 1'b1;
    burst_len_m1 = 4'd15;
    case (cur_burst)
      3'd0, 3'd1: begin
        burst_fixed  = 1'b0;
        burst_len_m1 = 4'd0;
      end
      3'd2, 3'd3: burst_len_m1 = 4'd3;
      3'd4, 3'd5: burst_len_m1 = 4'd7;
      default:    burst_len_m1 = 4'd15;
    endcase
  end

  // Beat counter value after an accepted transfer of the owner.
  always_comb begin
    beat_next = '0;
    case (cur_trans)
      TR_IDLE:   beat_next = '0;
      TR_BUSY:   beat_next = beat_q;
      TR_NONSEQ: beat_next = burst_fixed ? burst_len_m1 : 4'd0;
      TR_SEQ:    beat_next = (beat_q != 4'd0) ? beat_q - 4'd1 : 4'd0;
    endcase
  end

`ifdef AHB_ARB_RR_EN
  int rr_dist;
  int rr_best;

  // Round-robin: nearest requester above the owner, wrapping; the owner
  // itself sits at the largest distance so it wins only when alone.
  always_comb begin
    pick_idx = DEF_IDX;
    rr_best  = MASTER_NUMBER + 1;
    rr_dist  = 0;
    for (int i = 0; i < MASTER_NUMBER; i++) begin
      rr_dist = i - int'(owner_q);
      if (rr_dist <= 0) rr_dist = rr_dist + MASTER_NUMBER;
      if (busreq[i] && (rr_dist < rr_best)) begin
        rr_best  = rr_dist;
        pick_idx = 4'(i);
      end
    end
  end
`else
  // Fixed priority: lowest-index requester wins.
  always_comb begin
    pick_idx = DEF_IDX;
    for (int i = MASTER_NUMBER - 1; i >= 0; i--) begin
      if (busreq[i]) pick_idx = 4'(i);
    end
  end
`endif

  assign lock_enter = cur_lock & cur_req;
  assign err_exit   = (state_q == ST_BURST) && !hready && (hresp != RESP_OKAY);

  // Next-state, beat count and grant decision.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    owner_d = owner_q;
    grant_d = grant_q;
    regrant = 1'b0;
    if (hready) begin
      beat_d = beat_next;
      case (state_q)
        ST_ARB: begin
          if (lock_enter) begin
            state_d = ST_LOCKED;
          end else if (cur_trans == TR_NONSEQ && burst_fixed) begin
            state_d = ST_BURST;
          end else if ((cur_trans == TR_SEQ || cur_trans == TR_BUSY) &&
                       cur_burst == HB_INCR && cur_req) begin
            state_d = ST_ARB;
          end else begin
            regrant = 1'b1;
          end
        end
        ST_BURST: begin
          if (lock_enter) begin
            state_d = ST_LOCKED;
          end else if (beat_next == 4'd0) begin
            state_d = ST_ARB;
            regrant = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!cur_lock) begin
            if (beat_next != 4'd0) begin
              state_d = ST_BURST;
            end else begin
              state_d = ST_ARB;
              regrant = 1'b1;
            end
          end
        end
        default: state_d = ST_ARB;
      endcase
    end else if (err_exit) begin
      // First cycle of a two-cycle error response ends the burst at once.
      state_d = ST_ARB;
      beat_d  = '0;
      regrant = 1'b1;
    end
    if (regrant) begin
      owner_d = pick_idx;
      for (int i = 0; i < MASTER_NUMBER; i++) begin
        grant_d[i] = (pick_idx == 4'(i));
      end
    end
  end

  // Arbitration state, beat counter and registered grant.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      state_q <= ST_ARB;
      beat_q  <= '0;
      owner_q <= DEF_IDX;
      grant_q <= DEF_GRANT;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
    end
  end

  // Address/data-phase owner pipeline and lock indication, advanced by HREADY.
  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      hmaster_q      <= DEF_IDX;
      hmaster_data_q <= DEF_IDX;
      hmastlock_q    <= 1'b0;
    end else if (hready) begin
      hmaster_q      <= owner_q;
      hmaster_data_q <= hmaster_q;
      hmastlock_q    <= cur_lock & cur_req;
    end
  end

  assign hgrant    = grant_q;
  assign hmaster   = hmaster_q;
  assign hmaster_d = hmaster_data_q;
  assign hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Self-checking bench for ahb_rr_arbiter: vector table, directed corner
// sequences and randomized traffic against a behavioural model. Expected
// values follow whichever build (AHB_ARB_RR_EN or not) is compiled.
module tb_ahb_rr_arbiter;
  localparam int N   = 4;
  localparam int DEF = 0;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] HB_SINGLE = 3'd0;
  localparam logic [2:0] HB_INCR4  = 3'd3;
  localparam logic [2:0] HB_WRAP8  = 3'd4;
  localparam logic [2:0] HB_INCR8  = 3'd5;

  logic           hclk = 1'b0;
  logic           hreset;
  logic [N-1:0]   busreq;
  logic [N-1:0]   hlock;
  logic [2*N-1:0] htrans;
  logic [3*N-1:0] hburst;
  logic           hready;
  logic [1:0]     hresp;
  logic [N-1:0]   hgrant;
  logic [3:0]     hmaster;
  logic [3:0]     hmaster_d;
  logic           hmastlock;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state
  int m_owner;
  int m_rem;
  bit m_locked;
  int e_hm;
  int e_hmd;
  bit e_lock;

  ahb_rr_arbiter #(.MASTER_NUMBER(N), .DEFAULT_MASTER(DEF)) dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .busreq    (busreq),
    .hlock     (hlock),
    .htrans    (htrans),
    .hburst    (hburst),
    .hready    (hready),
    .hresp     (hresp),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmaster_d (hmaster_d),
    .hmastlock (hmastlock)
  );

  always #5 hclk = ~hclk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  function automatic int pick_model(logic [N-1:0] req, int owner);
    if (req == '0) return DEF;
`ifdef AHB_ARB_RR_EN
    for (int k = 1; k <= N; k++) begin
      if (req[(owner + k) % N]) return (owner + k) % N;
    end
`else
    for (int i = 0; i < N; i++) begin
      if (req[i]) return i;
    end
`endif
    return DEF;
  endfunction

  task automatic model_reset();
    m_owner  = DEF;
    m_rem    = 0;
    m_locked = 0;
    e_hm     = DEF;
    e_hmd    = DEF;
    e_lock   = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    int  tr, bu, nrem;
    bit  lk, rq, regrant;
    tr      = int'(htrans[2*m_owner +: 2]);
    bu      = int'(hburst[3*m_owner +: 3]);
    lk      = hlock[m_owner];
    rq      = busreq[m_owner];
    regrant = 0;
    if (hready) begin
      case (tr)
        0:       nrem = 0;
        1:       nrem = m_rem;
        2:       nrem = (bu >= 2) ? (4 << ((bu - 2) / 2)) - 1 : 0;
        default: nrem = (m_rem > 0) ? m_rem - 1 : 0;
      endcase
      if (m_locked) begin
        if (!lk) begin
          m_locked = 0;
          regrant  = (nrem == 0);
        end
      end else if (lk && rq) begin
        m_locked = 1;
      end else if (m_rem == 0) begin
        if (nrem != 0) regrant = 0;
        else if ((tr == 3 || tr == 1) && bu == 1 && rq) regrant = 0;
        else regrant = 1;
      end else begin
        regrant = (nrem == 0);
      end
      e_hmd  = e_hm;
      e_hm   = m_owner;
      e_lock = lk && rq;
      m_rem  = nrem;
    end else if (hresp != 2'b00 && !m_locked && m_rem != 0) begin
      m_rem   = 0;
      regrant = 1;
    end
    if (regrant) m_owner = pick_model(busreq, m_owner);
  endtask

  task automatic check_model();
    check("model_hgrant",    32'(hgrant),    32'(1) << m_owner);
    check("model_hmaster",   32'(hmaster),   32'(e_hm));
    check("model_hmaster_d", 32'(hmaster_d), 32'(e_hmd));
    check("model_hmastlock", 32'(hmastlock), 32'(e_lock));
  endtask

  task automatic cycle();
    model_step();
    @(posedge hclk);
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    busreq = '0;
    hlock  = '0;
    htrans = '0;
    hburst = '0;
    hready = 1'b1;
    hresp  = 2'b00;
  endtask

  task automatic set_tr(int m, logic [1:0] t, logic [2:0] b);
    htrans[2*m +: 2] = t;
    hburst[3*m +: 3] = b;
  endtask

  task automatic apply_reset();
    idle_inputs();
    hreset = 1'b0;
    model_reset();
    @(posedge hclk);
    #1;
    check("rst_hgrant",    32'(hgrant),    32'(1) << DEF);
    check("rst_hmaster",   32'(hmaster),   32'(DEF));
    check("rst_hmaster_d", 32'(hmaster_d), 32'(DEF));
    check("rst_hmastlock", 32'(hmastlock), 32'd0);
    hreset = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic         rdy;
    logic [N-1:0] exp_grant;
    logic [3:0]   exp_hm;
  } vec_t;

  task automatic run_table();
    vec_t vecs [9];
`ifdef AHB_ARB_RR_EN
    vecs[0] = '{4'b0101, 1'b1, 4'b0100, 4'd0};
    vecs[1] = '{4'b0101, 1'b1, 4'b0001, 4'd2};
    vecs[2] = '{4'b0101, 1'b1, 4'b0100, 4'd0};
    vecs[3] = '{4'b0000, 1'b1, 4'b0001, 4'd2};
    vecs[4] = '{4'b1010, 1'b0, 4'b0001, 4'd2};
    vecs[5] = '{4'b1010, 1'b1, 4'b0010, 4'd0};
    vecs[6] = '{4'b1010, 1'b1, 4'b1000, 4'd1};
    vecs[7] = '{4'b1000, 1'b1, 4'b1000, 4'd3};
    vecs[8] = '{4'b1000, 1'b1, 4'b1000, 4'd3};
`else
    vecs[0] = '{4'b0101, 1'b1, 4'b0001, 4'd0};
    vecs[1] = '{4'b0101, 1'b1, 4'b0001, 4'd0};
    vecs[2] = '{4'b0101, 1'b1, 4'b0001, 4'd0};
    vecs[3] = '{4'b0000, 1'b1, 4'b0001, 4'd0};
    vecs[4] = '{4'b1010, 1'b0, 4'b0001, 4'd0};
    vecs[5] = '{4'b1010, 1'b1, 4'b0010, 4'd0};
    vecs[6] = '{4'b1010, 1'b1, 4'b0010, 4'd1};
    vecs[7] = '{4'b1000, 1'b1, 4'b1000, 4'd1};
    vecs[8] = '{4'b1000, 1'b1, 4'b1000, 4'd3};
`endif
    apply_reset();
    htrans = {N{TR_NONSEQ}};
    hburst = {N{HB_SINGLE}};
    for (int i = 0; i < 9; i++) begin
      busreq = vecs[i].req;
      hready = vecs[i].rdy;
      cycle();
      check("tbl_hgrant",  32'(hgrant),  32'(vecs[i].exp_grant));
      check("tbl_hmaster", 32'(hmaster), 32'(vecs[i].exp_hm));
    end
  endtask

  // Reset asserted in the middle of a locked INCR8.
  task automatic seq_reset_mid_burst();
    apply_reset();
    busreq = 4'b0010;
    cycle();
    check("rb_setup_grant", 32'(hgrant), 32'b0010);
    hlock = 4'b0010;
    set_tr(1, TR_NONSEQ, HB_INCR8);
    cycle();
    check("rb_lock_on", 32'(hmastlock), 32'd1);
    set_tr(1, TR_SEQ, HB_INCR8);
    cycle();
    #3 hreset = 1'b0;
    #1;
    check("rb_async_hgrant",    32'(hgrant),    32'b0001);
    check("rb_async_hmaster",   32'(hmaster),   32'd0);
    check("rb_async_hmaster_d", 32'(hmaster_d), 32'd0);
    check("rb_async_hmastlock", 32'(hmastlock), 32'd0);
    model_reset();
    idle_inputs();
    busreq = 4'b0110;
    #1 hreset = 1'b1;
    cycle();
    check("rb_first_grant", 32'(hgrant), 32'b0010);
  endtask

  // INCR4 from master 1 with BUSY beats and stalls while master 3 waits.
  task automatic seq_incr4();
    logic [1:0]   tr  [8];
    logic         rdy [8];
    logic [N-1:0] exp_last;
    tr  = '{TR_NONSEQ, TR_BUSY, TR_SEQ, TR_SEQ, TR_BUSY, TR_SEQ, TR_SEQ, TR_SEQ};
    rdy = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`ifdef AHB_ARB_RR_EN
    exp_last = 4'b1000;
`else
    exp_last = 4'b0010;
`endif
    apply_reset();
    busreq = 4'b1010;
    cycle();
    check("i4_setup_grant", 32'(hgrant), 32'b0010);
    for (int i = 0; i < 8; i++) begin
      set_tr(1, tr[i], HB_INCR4);
      hready = rdy[i];
      cycle();
      if (i < 7) check("i4_hold_grant", 32'(hgrant), 32'b0010);
      else       check("i4_last_grant", 32'(hgrant), 32'(exp_last));
    end
    set_tr(1, TR_IDLE, HB_SINGLE);
    cycle();
  endtask

  // WRAP8 from master 1 terminated by an ERROR response on beat 3.
  task automatic seq_wrap8_error();
    logic [N-1:0] exp_err;
`ifdef AHB_ARB_RR_EN
    exp_err = 4'b1000;
`else
    exp_err = 4'b0010;
`endif
    apply_reset();
    busreq = 4'b1010;
    cycle();
    set_tr(1, TR_NONSEQ, HB_WRAP8);
    cycle();
    set_tr(1, TR_SEQ, HB_WRAP8);
    cycle();
    cycle();
    check("w8_pre_err_grant", 32'(hgrant), 32'b0010);
    hready = 1'b0;
    hresp  = 2'b01;
    cycle();
    check("w8_err_grant",       32'(hgrant),  32'(exp_err));
    check("w8_err_hmaster_frz", 32'(hmaster), 32'd1);
    hready = 1'b1;
    set_tr(1, TR_IDLE, HB_SINGLE);
    cycle();
    hresp = 2'b00;
    cycle();
  endtask

  // Master 2 locks across two INCR4 bursts while masters 0 and 3 request.
  task automatic seq_locked_bursts();
    logic [N-1:0] exp_rel;
`ifdef AHB_ARB_RR_EN
    exp_rel = 4'b1000;
`else
    exp_rel = 4'b0001;
`endif
    apply_reset();
    busreq = 4'b1100;
    cycle();
    check("lk_setup_grant", 32'(hgrant), 32'b0100);
    busreq = 4'b1101;
    hlock  = 4'b1100;
    for (int i = 0; i < 8; i++) begin
      set_tr(2, (i % 4 == 0) ? TR_NONSEQ : TR_SEQ, HB_INCR4);
      cycle();
      check("lk_frozen_grant", 32'(hgrant),    32'b0100);
      check("lk_hmastlock",    32'(hmastlock), 32'd1);
    end
    hlock = 4'b1000;
    set_tr(2, TR_IDLE, HB_SINGLE);
    cycle();
    check("lk_release_grant", 32'(hgrant),    32'(exp_rel));
    check("lk_release_mlock", 32'(hmastlock), 32'd0);
  endtask

  // Masters 1 and 3 both request single transfers.
  task automatic seq_priority();
    logic [N-1:0] exp_g;
    apply_reset();
    busreq = 4'b1010;
    set_tr(1, TR_NONSEQ, HB_SINGLE);
    set_tr(3, TR_NONSEQ, HB_SINGLE);
    for (int i = 0; i < 6; i++) begin
`ifdef AHB_ARB_RR_EN
      exp_g = (i % 2 == 0) ? 4'b0010 : 4'b1000;
`else
      exp_g = 4'b0010;
`endif
      cycle();
      check("pr_grant", 32'(hgrant), 32'(exp_g));
    end
    busreq = 4'b1000;
    cycle();
    check("pr_after_drop", 32'(hgrant), 32'b1000);
  endtask

  task automatic run_random(int cycles);
    apply_reset();
    for (int c = 0; c < cycles; c++) begin
      busreq = N'($urandom);
      hlock  = ($urandom % 4 == 0) ? (N'($urandom) & N'($urandom)) : '0;
      htrans = (2*N)'($urandom);
      hburst = (3*N)'($urandom);
      hready = ($urandom % 5) != 0;
      hresp  = ($urandom % 6 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      cycle();
    end
  endtask

  initial begin
    run_table();
    seq_reset_mid_burst();
    seq_incr4();
    seq_wrap8_error();
    seq_locked_bursts();
    seq_priority();
    run_random(400);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
